// File: rtl/burst_serial_receiver_pkg.sv
// rtl/burst_serial_receiver_pkg.sv - shared word width, bit counter width and receiver FSM states
package burst_serial_receiver_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int BIT_CNT_W      = $clog2(DATA_WIDTH_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/burst_serial_receiver_if.sv
// rtl/burst_serial_receiver_if.sv - serial input, word output and status bundle with master/slave views
interface burst_serial_receiver_if #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4
);

  localparam int WCW = $clog2(BURST_LEN + 1);

  logic                  serial_in;
  logic                  serial_valid;
  logic                  end_of_transmission;
  logic [DATA_WIDTH-1:0] word_out;
  logic                  word_valid;
  logic                  word_ready;
  logic [WCW-1:0]        word_count;
  logic                  burst_done;
  logic                  frame_error;
  logic                  overflow;

  modport master (
    output serial_in, serial_valid, end_of_transmission, word_ready,
    input  word_out, word_valid, word_count, burst_done, frame_error, overflow
  );

  modport slave (
    input  serial_in, serial_valid, end_of_transmission, word_ready,
    output word_out, word_valid, word_count, burst_done, frame_error, overflow
  );

endinterface

// File: rtl/burst_serial_receiver_sync_word_fifo.sv
// rtl/burst_serial_receiver_sync_word_fifo.sv - small first-word fall-through word FIFO
module sync_word_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so the output is clean after reset.
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/burst_serial_receiver.sv
// rtl/burst_serial_receiver.sv - serial-to-word reassembly with framing check, burst counting and word FIFO
module burst_serial_receiver
  import burst_serial_receiver_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  burst_serial_receiver_if.slave bus
);

  localparam int WCW = $clog2(BURST_LEN + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [WCW-1:0]       LAST_WORD = WCW'(BURST_LEN - 1);

  rx_state_e             state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-2:0] shreg_q, shreg_d;
  logic [WCW-1:0]        word_count_q, word_count_d;
  logic                  burst_done_q, burst_done_d;
  logic                  frame_error_q, frame_error_d;
  logic                  overflow_q, overflow_d;

  logic                  push;
  logic [DATA_WIDTH-1:0] push_word;
  logic                  fifo_full, fifo_empty, pop;

  assign pop = !fifo_empty && bus.word_ready;

  // FSM next state, shifter, framing check and burst counting.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    word_count_d  = word_count_q;
    burst_done_d  = 1'b0;
    frame_error_d = 1'b0;
    overflow_d    = overflow_q;
    push          = 1'b0;
    push_word     = {shreg_q, bus.serial_in};
    if (bus.serial_valid) begin
      if (bus.end_of_transmission != (bit_cnt_q == LAST_BIT)) begin
        // Marker on the wrong bit, or last bit without marker: drop the word.
        frame_error_d = 1'b1;
        bit_cnt_d     = '0;
        state_d       = IDLE;
      end else if (bus.end_of_transmission) begin
        push      = 1'b1;
        bit_cnt_d = '0;
        state_d   = IDLE;
        if (fifo_full && !pop) overflow_d = 1'b1;
        if (word_count_q == LAST_WORD) begin
          word_count_d = '0;
          burst_done_d = 1'b1;
        end else begin
          word_count_d = word_count_q + 1'b1;
        end
      end else begin
        shreg_d   = {shreg_q[DATA_WIDTH-3:0], bus.serial_in};
        bit_cnt_d = bit_cnt_q + 1'b1;
        state_d   = SHIFT;
      end
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      word_count_q  <= '0;
      burst_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      word_count_q  <= word_count_d;
      burst_done_q  <= burst_done_d;
      frame_error_q <= frame_error_d;
      overflow_q    <= overflow_d;
    end
  end

  sync_word_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (bus.word_out)
  );

  assign bus.word_valid  = !fifo_empty;
  assign bus.word_count  = word_count_q;
  assign bus.burst_done  = burst_done_q;
  assign bus.frame_error = frame_error_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: doc/burst_serial_receiver.md
Name: burst_serial_receiver

Overview:
Receive-side counterpart of the parallel-to-serial converter. Consumes its serial bit stream and per-word end_of_transmission marker, and reassembles 16-bit words. Queues the words in a small FIFO for the MRAM write path (valid/ready) and signals burst completion every BURST_LEN words.

Parameters:
DATA_WIDTH, 16, bits per serial word
BURST_LEN, 4, words per burst; burst_done pulses after this many accepted words
FIFO_DEPTH, 4, word FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
serial_in  input  1  serial data bit, MSB first
serial_valid  input  1  serial_in carries a valid bit this cycle
end_of_transmission  input  1  high together with the last (LSB) bit of each word
word_out  output  DATA_WIDTH  head-of-FIFO word (first-word fall-through)
word_valid  output  1  FIFO not empty
word_ready  input  1  consumer accepts word_out when word_valid&&word_ready
word_count  output  $clog2(BURST_LEN+1)  words completed in the current burst
burst_done  output  1  one-cycle pulse when the BURST_LEN-th word is pushed
frame_error  output  1  one-cycle pulse on framing violation
overflow  output  1  sticky: a completed word was dropped because the FIFO was full

Behaviour:
- Reset (rst high at a clk edge): all outputs 0, word_out 0, FIFO empty, bit_cnt 0, word_count 0, overflow cleared, FSM to IDLE. Reset mid-word or mid-burst discards all partial state.
- FSM states:
  - IDLE: waiting for the first valid bit. The first serial_valid moves to SHIFT and the bit is captured.
  - SHIFT: shifting bits in.
  - IDLE re-entered after each completed or aborted word.
- Shift: each serial_valid cycle does shreg <= {shreg[DATA_WIDTH-2:0], serial_in} and bit_cnt++. serial_valid low holds everything; gaps of any length are legal.
- Word completion: a valid bit with bit_cnt==DATA_WIDTH-1 AND end_of_transmission=1. The completed word {shreg, serial_in} is pushed to the FIFO. word_valid rises on the next clk edge (1-cycle latency from the last bit).
- Framing errors (frame_error pulses next cycle, partial word discarded, bit_cnt<=0, FSM to IDLE, word_count unchanged):
  - end_of_transmission=1 with bit_cnt!=DATA_WIDTH-1.
  - Last bit arrives without end_of_transmission.
- end_of_transmission while serial_valid=0: ignored.
- Burst counting: word_count increments on each push attempt of a well-framed word, dropped words included.
  - On reaching BURST_LEN: burst_done pulses and word_count returns to 0 in the same edge. word_count therefore never reads BURST_LEN.
- FIFO:
  - Pop on word_valid&&word_ready.
  - Push while full with no pop: word dropped, overflow<=1 (sticky until rst).
  - Push while full with a simultaneous pop: both occur, occupancy unchanged, no overflow.
  - Push while empty: the word appears on word_out next cycle.
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- word_out is stable while word_valid=1 and word_ready=0.

Decomposition:
- Shared package/include: DATA_WIDTH default, FSM state encodings (IDLE, SHIFT), and the bit_cnt width localparam. These are shared with the parallel-to-serial side so both ends agree on word width.
- One sub-module: sync_word_fifo (DATA_WIDTH, FIFO_DEPTH; push, pop, full, empty, dout, with fall-through head). The top level holds the FSM, shifter and counters.

Test Plan:
- Word 16'h5555 sent MSB first on consecutive cycles, end_of_transmission on bit 16, word_ready=1 -> word_valid high 1 cycle after the last bit with word_out=16'h5555, word_count=1, no frame_error.
- Four words 16'h5555, 16'hAAAA, 16'h0001, 16'h8000 with 3-cycle serial_valid gaps inside words -> words emitted in order; burst_done pulses once after the 4th; word_count 1,2,3,0.
- end_of_transmission asserted on bit 9 of a word -> frame_error 1-cycle pulse; no push. The next well-framed 16'h1234 is received correctly.
- word_ready=0, five words sent -> four stored, fifth dropped, overflow=1. Then word_ready=1 -> the first four popped in order, overflow stays 1.
- FIFO full, new word completes in the same cycle as a pop -> no overflow, occupancy stays 4, new word last in order.
- rst pulsed after 8 bits of a word with two words queued -> word_valid=0, word_count=0, overflow=0. A following full word is received cleanly.
